rpi_bus_rx: RTL
===============

// Module: rpi_bus_rx
// PURPOSE
//  Upstream stage of the LED/pin matrix scanner. Receives bytes from the Raspberry Pi 8-bit GPIO bus
//  using a 4-phase strobe/ack handshake, decodes command vs data, and issues single-cycle writes
//  (addr/data/en) into the matrix frame memory. Async RPi pins are synchronised here.
// PARAMETERS
//  ADDR_DEPTH     4     frame memory address width; MAX_ADDR = 2**ADDR_DEPTH-1
//  TIMEOUT_CYCLES 1023  strobe-stuck limit (used only with RPI_TIMEOUT_EN)
// PORTS
//  clk_100mhz  in   1           system clock
//  rst         in   1           synchronous, active-high reset
//  RPI_IO      in   8           async data bus from RPi
//  rpi_strobe  in   1           async; RPi raises when RPI_IO/rpi_cmd valid
//  rpi_cmd     in   1           async; 1 = command byte, 0 = data byte
//  rpi_ack     out  1           handshake ack to RPi
//  wr_en       out  1           1-cycle memory write pulse
//  wr_addr     out  ADDR_DEPTH  write address
//  wr_data     out  8           write data
//  frame_done  out  1           1-cycle pulse on COMMIT
//  err         out  1           1-cycle pulse on reserved opcode (or timeout)
// BEHAVIOUR
//  - Reset: all outputs 0, pointer 0, FSM IDLE, synchronisers cleared. rst mid-handshake drops rpi_ack next edge.
//  - RPI_IO, rpi_cmd, rpi_strobe each pass 2-FF sync; strobe edge detected on synced copy vs 1-cycle delay.
//  - FSM: IDLE -> (synced strobe rise) EXEC -> ACK -> (synced strobe low) IDLE.
//    IDLE: rpi_ack=0. EXEC (1 cycle): decode sampled byte, drive wr_en/frame_done/err as below.
//    ACK: rpi_ack=1 held until synced strobe=0, then IDLE with rpi_ack=0 next cycle.
//  - Latency: strobe rise at pin -> edge seen cycle 3 -> EXEC outputs at cycle 4 -> rpi_ack=1 at cycle 5.
//  - Data byte (cmd=0): wr_en=1, wr_addr=ptr, wr_data=byte; ptr<=ptr+1, MAX_ADDR wraps to 0.
//  - Command byte (cmd=1), opcode=byte[7:6]:
//    00 SET_ADDR: ptr<=byte[ADDR_DEPTH-1:0]; no write.   01 RESET_PTR: ptr<=0.
//    10 COMMIT: frame_done=1 one cycle; ptr unchanged.   11 reserved: err=1 one cycle; no state change.
//  - Still acked in all cases. wr_addr/wr_data hold last values when wr_en=0.
//  - Strobe rise while in EXEC/ACK ignored (protocol violation); only a fresh rise from IDLE counts.
//  - Strobe already high out of reset: not an edge; must go low then high.
// CONFIGURATION
//  RPI_TIMEOUT_EN defined: counter runs in ACK; reaching TIMEOUT_CYCLES with strobe still high ->
//    err=1 one cycle, rpi_ack=0, FSM to WAIT_LOW (ack low, waits strobe low, then IDLE).
//  Undefined: no counter, no WAIT_LOW state; ACK waits indefinitely.
// STRUCTURE
//  Shared package rpi_bus_pkg: opcode constants (OP_SET_ADDR=2'b00, OP_RESET_PTR=2'b01,
//    OP_COMMIT=2'b10, OP_RSVD=2'b11), FSM state encodings.
//  Sub-module sync_2ff (WIDTH param) for RPI_IO/rpi_cmd/rpi_strobe synchronisation.
// TESTING
//  1 After rst, data 0xA5 via handshake -> wr_en at cycle 4, wr_addr=0, wr_data=0xA5; rpi_ack=1 at cycle 5, 0 after strobe drop.
//  2 SET_ADDR 0x0E then data 0x11,0x22,0x33 -> writes at addr 14,15,0 (wrap).
//  3 RESET_PTR then COMMIT -> ptr=0, single frame_done pulse, no wr_en.
//  4 Command 0xC0 -> err pulse only, ptr/mem unchanged, still acked.
//  5 rst asserted while ACK -> rpi_ack=0 next cycle, next data writes to addr 0.
//  6 RPI_TIMEOUT_EN: hold strobe high 1100 cycles -> err at cycle TIMEOUT_CYCLES, ack drops, recovers after strobe low.

Source files
------------

// File: rtl/rpi_bus_pkg.sv
// Shared definitions for the Raspberry Pi bus receiver: command opcodes and FSM state encodings.
// Optional feature macro: RPI_TIMEOUT_EN adds the WAIT_LOW recovery state used after a stuck strobe.
package rpi_bus_pkg;

    localparam logic [1:0] OP_SET_ADDR  = 2'b00;
    localparam logic [1:0] OP_RESET_PTR = 2'b01;
    localparam logic [1:0] OP_COMMIT    = 2'b10;
    localparam logic [1:0] OP_RSVD      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_ACK      = 2'd2
`ifdef RPI_TIMEOUT_EN
       ,ST_WAIT_LOW = 2'd3
`endif
    } rx_state_t;

    // The opcode of a command byte lives in its two top bits
    function automatic logic [1:0] get_opcode(input logic [7:0] cmd_byte);
        return cmd_byte[7:6];
    endfunction

endpackage

// File: rtl/rpi_bus_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous Raspberry Pi pins, cleared by synchronous reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops give the first stage a full cycle to settle out of metastability
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rpi_bus_rx.sv
// rpi_bus_rx: receives bytes from the Raspberry Pi GPIO bus over a 4-phase strobe/ack handshake,
// decodes command vs data bytes and issues single-cycle writes into the matrix frame memory.
// Optional feature macro: RPI_TIMEOUT_EN enables the stuck-strobe timeout and WAIT_LOW recovery.
module rpi_bus_rx
    import rpi_bus_pkg::*;
#(
    parameter int ADDR_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk_100mhz,
    input  logic                  rst,
    input  logic [7:0]            RPI_IO,
    input  logic                  rpi_strobe,
    input  logic                  rpi_cmd,
    output logic                  rpi_ack,
    output logic                  wr_en,
    output logic [ADDR_DEPTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  frame_done,
    output logic                  err
);

    localparam logic [ADDR_DEPTH-1:0] MAX_ADDR = ADDR_DEPTH'((2 ** ADDR_DEPTH) - 1);

    // SET_ADDR takes the pointer from the low byte bits, so the address cannot exceed 8 bits
    if (ADDR_DEPTH < 1 || ADDR_DEPTH > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("rpi_bus_rx: ADDR_DEPTH must be 1..8 and TIMEOUT_CYCLES at least 2");
    end

    logic [9:0]       sync_in;
    logic [9:0]       sync_out;
    logic             strobe_sync;
    logic             cmd_sync;
    logic [7:0]       io_sync;
    logic             strobe_d;
    logic [1:0]       warm_cnt;
    logic             strobe_rise;
    rx_state_t        state;
    logic [7:0]       byte_q;
    logic             cmd_q;
    logic [ADDR_DEPTH-1:0] ptr;

    assign sync_in = {rpi_strobe, rpi_cmd, RPI_IO};

    sync_2ff #(
        .WIDTH(10)
    ) u_sync (
        .clk(clk_100mhz),
        .rst(rst),
        .d  (sync_in),
        .q  (sync_out)
    );

    assign strobe_sync = sync_out[9];
    assign cmd_sync    = sync_out[8];
    assign io_sync     = sync_out[7:0];
    assign strobe_rise = strobe_sync & ~strobe_d;

    // Strobe history is held high until the synchroniser has refilled after reset, so a strobe
    // already high at reset release is never mistaken for a rising edge
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            warm_cnt <= 2'd0;
            strobe_d <= 1'b1;
        end else begin
            if (warm_cnt != 2'd2) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
            strobe_d <= (warm_cnt == 2'd2) ? strobe_sync : 1'b1;
        end
    end

`ifdef RPI_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
`endif

    // Handshake FSM: capture byte on a fresh strobe rise, execute it for one cycle, then hold ack
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state      <= ST_IDLE;
            rpi_ack    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
            frame_done <= 1'b0;
            err        <= 1'b0;
            ptr        <= '0;
            byte_q     <= 8'h00;
            cmd_q      <= 1'b0;
`ifdef RPI_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rpi_ack <= 1'b0;
                    if (strobe_rise) begin
                        byte_q <= io_sync;
                        cmd_q  <= cmd_sync;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!cmd_q) begin
                        wr_en   <= 1'b1;
                        wr_addr <= ptr;
                        wr_data <= byte_q;
                        ptr     <= (ptr == MAX_ADDR) ? '0 : ptr + 1'b1;
                    end else begin
                        case (get_opcode(byte_q))
                            OP_SET_ADDR:  ptr        <= byte_q[ADDR_DEPTH-1:0];
                            OP_RESET_PTR: ptr        <= '0;
                            OP_COMMIT:    frame_done <= 1'b1;
                            OP_RSVD:      err        <= 1'b1;
                            default:      err        <= 1'b1;
                        endcase
                    end
`ifdef RPI_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    if (!strobe_sync) begin
                        rpi_ack <= 1'b0;
                        state   <= ST_IDLE;
`ifdef RPI_TIMEOUT_EN
                    end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err     <= 1'b1;
                        rpi_ack <= 1'b0;
                        state   <= ST_WAIT_LOW;
                    end else begin
                        to_cnt  <= to_cnt + 1'b1;
                        rpi_ack <= 1'b1;
`else
                    end else begin
                        rpi_ack <= 1'b1;
`endif
                    end
                end
`ifdef RPI_TIMEOUT_EN
                ST_WAIT_LOW: begin
                    rpi_ack <= 1'b0;
                    if (!strobe_sync) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    rpi_ack <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
